// File: rtl/cache_miss_fill_controller_pkg.sv
// Shared definitions for the cache miss fill controller.
// - fill_state_t : fill sequence states, IDLE through DONE
// - clog2        : constant ceiling-log2 used to derive the address widths
//                  BW_CACHE_CAPACITY and BW_OFFSET from the block parameters
package cache_miss_fill_controller_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    POLICY_REQ  = 3'd1,
    POLICY_WAIT = 3'd2,
    FILL        = 3'd3,
    TAG_WR      = 3'd4,
    DONE        = 3'd5
  } fill_state_t;

  localparam int DEF_CACHE_BLOCK_CAPACITY = 16;
  localparam int DEF_BLOCK_WORDS          = 4;
  localparam int DEF_BW_TAG               = 24;
  localparam int DEF_BW_WORD              = 32;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_miss_fill_controller.sv
// Cache miss fill controller: initiator side of the replacement-policy
// handshake. A miss pulses the policy controller, captures the victim block,
// reads BLOCK_WORDS words from the next memory level into the data array at
// the victim block, then writes the {valid, tag} entry and pulses fill_done_o.
// Ports:
//   clock_i, resetn_i          clock (rising edge), async active-low reset
//   miss_i, miss_tag_i         fill request and tag of the missed block
//   busy_o, fill_done_o        busy from accept to done, completion pulse
//   policy_req_o               one-cycle pulse to the policy controller
//   policy_done_i/addr_i       policy response (done is sticky) and victim
//   mem_req_o, mem_addr_o      block read request and word address {tag, 0}
//   mem_valid_i, mem_data_i    returned memory words
//   cache_we_o/addr_o/data_o   data array write port {victim, offset}
//   tag_we_o/addr_o/data_o     tag array write port, data {1'b1, tag}
// All outputs are registered.
module cache_miss_fill_controller
  import cache_miss_fill_controller_pkg::*;
#(
  parameter int CACHE_BLOCK_CAPACITY = DEF_CACHE_BLOCK_CAPACITY,
  parameter int BLOCK_WORDS          = DEF_BLOCK_WORDS,
  parameter int BW_TAG               = DEF_BW_TAG,
  parameter int BW_WORD              = DEF_BW_WORD,
  localparam int BW_CACHE_CAPACITY   = clog2(CACHE_BLOCK_CAPACITY),
  localparam int BW_OFFSET           = clog2(BLOCK_WORDS)
) (
  input  logic                                 clock_i,
  input  logic                                 resetn_i,
  input  logic                                 miss_i,
  input  logic [BW_TAG-1:0]                    miss_tag_i,
  output logic                                 busy_o,
  output logic                                 fill_done_o,
  output logic                                 policy_req_o,
  input  logic                                 policy_done_i,
  input  logic [BW_CACHE_CAPACITY-1:0]         policy_addr_i,
  output logic                                 mem_req_o,
  output logic [BW_TAG+BW_OFFSET-1:0]          mem_addr_o,
  input  logic                                 mem_valid_i,
  input  logic [BW_WORD-1:0]                   mem_data_i,
  output logic                                 cache_we_o,
  output logic [BW_CACHE_CAPACITY+BW_OFFSET-1:0] cache_addr_o,
  output logic [BW_WORD-1:0]                   cache_data_o,
  output logic                                 tag_we_o,
  output logic [BW_CACHE_CAPACITY-1:0]         tag_addr_o,
  output logic [BW_TAG:0]                      tag_data_o
);

  localparam logic [BW_OFFSET-1:0] LAST_WORD = BW_OFFSET'(BLOCK_WORDS - 1);

  fill_state_t                  state;
  fill_state_t                  state_next;
  logic [BW_TAG-1:0]            tag_q;
  logic [BW_CACHE_CAPACITY-1:0] victim_q;
  logic [BW_OFFSET-1:0]         word_cnt;
  logic                         word_accept;
  logic                         last_word;
  logic                         victim_take;

  assign word_accept = (state == FILL) && mem_valid_i;
  assign last_word   = word_accept && (word_cnt == LAST_WORD);
  // policy_done_i is sticky, so it is only trusted after the request cycle.
  assign victim_take = (state == POLICY_WAIT) && policy_done_i;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        if (miss_i) state_next = POLICY_REQ;
      POLICY_REQ:  state_next = POLICY_WAIT;
      POLICY_WAIT: if (policy_done_i) state_next = FILL;
      FILL:        if (last_word) state_next = TAG_WR;
      TAG_WR:      state_next = DONE;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Sequence state, captured miss tag, victim and word offset
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state    <= IDLE;
      tag_q    <= '0;
      victim_q <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && miss_i) tag_q <= miss_tag_i;
      if (victim_take) victim_q <= policy_addr_i;
      // Wraps to 0 on the last word, ready for the next fill.
      if (word_accept) word_cnt <= word_cnt + BW_OFFSET'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      busy_o       <= 1'b0;
      fill_done_o  <= 1'b0;
      policy_req_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      cache_we_o   <= 1'b0;
      cache_addr_o <= '0;
      cache_data_o <= '0;
      tag_we_o     <= 1'b0;
      tag_addr_o   <= '0;
      tag_data_o   <= '0;
    end else begin
      busy_o       <= (state_next != IDLE);
      fill_done_o  <= (state == TAG_WR);
      policy_req_o <= (state == IDLE) && miss_i;
      // Held across the whole fill; drops on the edge taking the last word.
      mem_req_o    <= (state_next == FILL);
      cache_we_o   <= word_accept;
      tag_we_o     <= last_word;
      if (victim_take) mem_addr_o <= {tag_q, {BW_OFFSET{1'b0}}};
      if (word_accept) begin
        cache_addr_o <= {victim_q, word_cnt};
        cache_data_o <= mem_data_i;
      end
      if (last_word) begin
        tag_addr_o <= victim_q;
        tag_data_o <= {1'b1, tag_q};
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_fill_controller.sv
module tb_cache_miss_fill_controller;
  localparam int CAP    = 16;
  localparam int BW     = 4;
  localparam int BW_TAG = 24;
  localparam int BW_WRD = 32;
  localparam int BW_CAP = $clog2(CAP);
  localparam int BW_OFF = $clog2(BW);

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic miss = 1'b0;
  logic [BW_TAG-1:0] miss_tag = '0;
  logic policy_done;
  logic [BW_CAP-1:0] policy_addr;
  logic mem_valid;
  logic [BW_WRD-1:0] mem_data;

  logic busy_o, fill_done_o, policy_req_o, mem_req_o, cache_we_o, tag_we_o;
  logic [BW_TAG+BW_OFF-1:0] mem_addr_o;
  logic [BW_CAP+BW_OFF-1:0] cache_addr_o;
  logic [BW_WRD-1:0] cache_data_o;
  logic [BW_CAP-1:0] tag_addr_o;
  logic [BW_TAG:0] tag_data_o;

  always #5 clock = ~clock;

  cache_miss_fill_controller dut (
    .clock_i(clock), .resetn_i(resetn),
    .miss_i(miss), .miss_tag_i(miss_tag),
    .busy_o(busy_o), .fill_done_o(fill_done_o),
    .policy_req_o(policy_req_o), .policy_done_i(policy_done), .policy_addr_i(policy_addr),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid), .mem_data_i(mem_data),
    .cache_we_o(cache_we_o), .cache_addr_o(cache_addr_o), .cache_data_o(cache_data_o),
    .tag_we_o(tag_we_o), .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o)
  );

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Stimulus knobs
  bit sticky_mode = 1;
  int pol_max_delay = 0;
  int valid_pct = 100;
  int gap = 0;
  bit garbage = 0;
  bit seq_data = 1;

  // Policy controller stand-in: FIFO victim order, answers one or more
  // cycles after the request pulse; done either stays high or drops.
  logic [BW_CAP-1:0] pol_cnt;
  initial begin
    int d;
    policy_done = 1'b0;
    policy_addr = '0;
    pol_cnt = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        policy_done = 1'b0;
        policy_addr = '0;
        pol_cnt = '0;
      end else if (policy_req_o) begin
        if (!sticky_mode) policy_done = 1'b0;
        d = sticky_mode ? 0 : $urandom_range(pol_max_delay, 0);
        @(posedge clock);
        repeat (d) @(posedge clock);
        #1;
        if (resetn) begin
          policy_addr = pol_cnt;
          pol_cnt = pol_cnt + 1'b1;
          policy_done = 1'b1;
        end
      end
    end
  end

  // Memory stand-in: returns BW words per request, with gaps as configured,
  // and stray valids outside requests when garbage is set.
  initial begin
    int sent;
    int gap_left;
    mem_valid = 1'b0;
    mem_data = '0;
    sent = 0;
    gap_left = 0;
    forever begin
      @(negedge clock);
      mem_valid = 1'b0;
      mem_data = BW_WRD'($urandom);
      if (!resetn || !mem_req_o) begin
        sent = 0;
        gap_left = 0;
        if (resetn && garbage) mem_valid = ($urandom_range(3, 0) == 0);
      end else if (sent < BW) begin
        if (gap_left > 0) gap_left = gap_left - 1;
        else if ($urandom_range(99, 0) < valid_pct) begin
          mem_valid = 1'b1;
          if (seq_data) mem_data = BW_WRD'(32'h11 * (sent + 1));
          sent = sent + 1;
          gap_left = gap;
        end
      end
    end
  end

  // Behavioural model: a fill is a sequence of phases counted per edge;
  // addresses come from arithmetic (victim*BW + offset, tag*BW).
  int m_ph, m_words, m_vic;
  logic [63:0] m_tag;
  bit e_busy, e_preq, e_mreq, e_we, e_twe, e_done;
  logic [63:0] e_maddr, e_caddr, e_cdata, e_taddr, e_tdata;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_ph = 0; m_words = 0; m_vic = 0; m_tag = '0;
      e_busy = 0; e_preq = 0; e_mreq = 0; e_we = 0; e_twe = 0; e_done = 0;
      e_maddr = '0; e_caddr = '0; e_cdata = '0; e_taddr = '0; e_tdata = '0;
    end else begin
      e_preq = 0; e_we = 0; e_twe = 0; e_done = 0;
      case (m_ph)
        0: if (miss) begin
             m_tag = 64'(miss_tag); m_ph = 1; e_preq = 1; e_busy = 1;
           end
        1: m_ph = 2;
        2: if (policy_done) begin
             m_vic = int'(policy_addr); m_ph = 3; e_mreq = 1;
             e_maddr = m_tag * BW;
           end
        3: if (mem_valid) begin
             e_we = 1;
             e_caddr = 64'(m_vic * BW + m_words);
             e_cdata = 64'(mem_data);
             m_words = m_words + 1;
             if (m_words == BW) begin
               m_words = 0; e_mreq = 0; e_twe = 1; m_ph = 4;
               e_taddr = 64'(m_vic);
               e_tdata = (64'd1 << BW_TAG) | m_tag;
             end
           end
        4: begin e_done = 1; m_ph = 5; end
        default: begin e_busy = 0; m_ph = 0; end
      endcase
    end
  end

  // Compare process plus logs used by the directed checks
  logic [63:0] waddr[$];
  logic [63:0] wdata[$];
  logic [63:0] last_taddr = '0, last_tdata = '0, first_maddr = '0;
  int n_preq = 0, n_done = 0, n_twe = 0;
  bit mreq_prev = 0;

  always @(negedge clock) begin
    chk("ctrl", 64'({busy_o, policy_req_o, mem_req_o, cache_we_o, tag_we_o, fill_done_o}),
        64'({e_busy, e_preq, e_mreq, e_we, e_twe, e_done}));
    if (e_mreq) chk("mem_addr", 64'(mem_addr_o), e_maddr);
    if (e_we) begin
      chk("cache_addr", 64'(cache_addr_o), e_caddr);
      chk("cache_data", 64'(cache_data_o), e_cdata);
    end
    if (e_twe) begin
      chk("tag_addr", 64'(tag_addr_o), e_taddr);
      chk("tag_data", 64'(tag_data_o), e_tdata);
    end
    if (cache_we_o) begin
      waddr.push_back(64'(cache_addr_o));
      wdata.push_back(64'(cache_data_o));
    end
    if (tag_we_o) begin
      last_taddr = 64'(tag_addr_o);
      last_tdata = 64'(tag_data_o);
      n_twe = n_twe + 1;
    end
    if (policy_req_o) n_preq = n_preq + 1;
    if (fill_done_o) n_done = n_done + 1;
    if (mem_req_o && !mreq_prev) first_maddr = 64'(mem_addr_o);
    mreq_prev = mem_req_o;
  end

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (fill_done_o) begin seen = 1; break; end
    end
    if (!seen) chk("fill_done_timeout", 64'd0, 64'd1);
    #1;
  endtask

  int exp_vic = 0;

  task automatic do_fill(input logic [BW_TAG-1:0] tag);
    @(negedge clock);
    miss = 1'b1; miss_tag = tag;
    @(negedge clock);
    miss = 1'b0;
    wait_done(200);
    chk("victim", last_taddr, 64'(exp_vic % CAP));
    chk("fill_tag", last_tdata, (64'd1 << BW_TAG) | 64'(tag));
    exp_vic = exp_vic + 1;
  endtask

  initial begin
    int base, p0, d0, t0;
    bit seen;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_outs", 64'({policy_req_o, mem_req_o, cache_we_o, tag_we_o, fill_done_o}), 64'd0);
    resetn = 1'b1;

    // First fill, pinned by hand-computed values
    base = waddr.size(); p0 = n_preq; d0 = n_done;
    do_fill(24'h00ABCD);
    chk("first_mem_addr", first_maddr, 64'h2AF34);
    chk("first_tag_addr", last_taddr, 64'd0);
    chk("first_tag_data", last_tdata, 64'h100ABCD);
    chk("first_preq_pulses", 64'(n_preq - p0), 64'd1);
    chk("first_done_pulses", 64'(n_done - d0), 64'd1);
    for (int i = 0; i < BW; i++) begin
      chk("first_waddr", waddr[base + i], 64'(i));
      chk("first_wdata", wdata[base + i], 64'(32'h11 * (i + 1)));
    end

    // Second fill lands on victim 1
    base = waddr.size();
    do_fill(24'h123456);
    chk("second_tag_addr", last_taddr, 64'd1);
    for (int i = 0; i < BW; i++) chk("second_waddr", waddr[base + i], 64'(4 + i));

    // Fifteen more: the seventeenth fill wraps to victim 0
    for (int i = 0; i < 15; i++) do_fill(BW_TAG'($urandom));
    chk("wrap_tag_addr", last_taddr, 64'd0);

    // Two idle cycles between words, stray valids outside the fill
    gap = 2; garbage = 1; base = waddr.size(); t0 = n_twe;
    do_fill(24'h0F0F0F);
    chk("gap_words", 64'(waddr.size() - base), 64'(BW));
    chk("gap_tag_writes", 64'(n_twe - t0), 64'd1);
    gap = 0; garbage = 0;

    // Sticky done already high with the previous victim on policy_addr
    chk("sticky_pre", 64'(policy_done), 64'd1);
    do_fill(24'hBEEF01);

    // Misses during FILL and DONE are ignored; first IDLE cycle is accepted
    p0 = n_preq;
    @(negedge clock);
    miss = 1'b1; miss_tag = 24'h000111;
    @(negedge clock);
    miss = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (mem_req_o) begin seen = 1; break; end
    end
    if (!seen) chk("mem_req_timeout", 64'd0, 64'd1);
    miss = 1'b1; miss_tag = 24'hDEAD00;
    @(negedge clock);
    miss = 1'b0;
    wait_done(200);
    chk("ignored_fill_tag", last_tdata, (64'd1 << BW_TAG) | 64'h000111);
    exp_vic = exp_vic + 1;
    miss = 1'b1; miss_tag = 24'hDEAD01;
    @(negedge clock);
    miss_tag = 24'h000222;
    @(negedge clock);
    miss = 1'b0;
    wait_done(200);
    chk("idle_accept_tag", last_tdata, (64'd1 << BW_TAG) | 64'h000222);
    chk("idle_accept_preq", 64'(n_preq - p0), 64'd2);
    exp_vic = exp_vic + 1;

    // Asynchronous reset after two of four words
    @(negedge clock);
    base = waddr.size();
    miss = 1'b1; miss_tag = 24'h777777;
    @(negedge clock);
    miss = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (waddr.size() >= base + 2) begin seen = 1; break; end
    end
    if (!seen) chk("two_words_timeout", 64'd0, 64'd1);
    #2;
    d0 = n_done; t0 = n_twe;
    resetn = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({busy_o, policy_req_o, mem_req_o, cache_we_o, tag_we_o, fill_done_o}), 64'd0);
    chk("async_rst_addr", 64'({mem_addr_o, cache_addr_o, tag_addr_o}), 64'd0);
    chk("async_rst_data", 64'({cache_data_o, tag_data_o}), 64'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("abandon_done", 64'(n_done - d0), 64'd0);
    chk("abandon_tagwe", 64'(n_twe - t0), 64'd0);
    exp_vic = 0;
    base = waddr.size();
    do_fill(24'h00C0DE);
    for (int i = 0; i < BW; i++) begin
      chk("post_rst_waddr", waddr[base + i], 64'(i));
      chk("post_rst_wdata", wdata[base + i], 64'(32'h11 * (i + 1)));
    end

    // Randomized traffic: random misses (also while busy), policy delays,
    // memory gaps and stray valids, checked every cycle by the model
    sticky_mode = 0; pol_max_delay = 2; valid_pct = 60; garbage = 1; seq_data = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      miss = ($urandom_range(5, 0) == 0);
      miss_tag = BW_TAG'($urandom);
    end
    @(negedge clock);
    miss = 1'b0;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (!busy_o) begin seen = 1; break; end
    end
    chk("drain_idle", 64'(seen), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/cache_miss_fill_controller.md
Name: cache_miss_fill_controller

Overview:
- Initiator side of the replacement-policy handshake.
- On a core miss, pulses the policy controller's miss input, captures the returned victim block address, and fetches BLOCK_WORDS words from the next memory level.
- Writes those words into the cache data store at the victim block, then writes the tag/valid entry and signals completion.
- Sits between the cache hit/miss logic, the policy controller, the memory interface and the cache data and tag arrays.

Parameters:
- CACHE_BLOCK_CAPACITY, 16: number of cache blocks; power of two, at least 2. BW_CACHE_CAPACITY = CLOG2 of this.
- BLOCK_WORDS, 4: words per block; power of two, at least 2. BW_OFFSET = CLOG2 of this.
- BW_TAG, 24: tag width. A block's memory address is the tag.
- BW_WORD, 32: data word width.

Ports:
- clock_i  in  1  single clock, rising edge.
- resetn_i  in  1  reset, asynchronous, active-low.
- miss_i  in  1  one-cycle pulse requesting a fill. Ignored while busy_o=1.
- miss_tag_i  in  BW_TAG  tag of the missed block; sampled with miss_i.
- busy_o  out  1  high from the cycle after an accepted miss until fill_done_o.
- fill_done_o  out  1  one-cycle pulse when the fill is complete.
- policy_req_o  out  1  one-cycle pulse to the policy controller's miss input.
- policy_done_i  in  1  policy controller done (sticky; may already be high).
- policy_addr_i  in  BW_CACHE_CAPACITY  victim block address from the policy controller.
- mem_req_o  out  1  block read request, held until the last word arrives.
- mem_addr_o  out  BW_TAG+BW_OFFSET  word address {tag, BW_OFFSET'b0}.
- mem_valid_i  in  1  memory word valid.
- mem_data_i  in  BW_WORD  memory word.
- cache_we_o  out  1  data array write enable.
- cache_addr_o  out  BW_CACHE_CAPACITY+BW_OFFSET  {victim, word offset}.
- cache_data_o  out  BW_WORD  write data.
- tag_we_o  out  1  tag array write enable.
- tag_addr_o  out  BW_CACHE_CAPACITY  victim block address.
- tag_data_o  out  BW_TAG+1  {valid=1, tag}.

Behaviour:
- Reset: asynchronous on resetn_i low. All outputs and registers clear to 0; state returns to IDLE; word counter clears to 0. Reset mid-fill abandons the fill: no tag write and no fill_done_o. All outputs are registered.
- State machine: IDLE -> POLICY_REQ -> POLICY_WAIT -> FILL -> TAG_WR -> DONE -> IDLE.
- IDLE: if miss_i=1, latch miss_tag_i and go to POLICY_REQ.
- POLICY_REQ:
  - policy_req_o=1 for exactly one cycle; busy_o=1.
  - policy_done_i is ignored in this cycle, because the policy done signal is sticky and can be stale.
- POLICY_WAIT:
  - On the first cycle with policy_done_i=1, capture policy_addr_i as the victim.
  - Assert mem_req_o and mem_addr_o={tag, 0} on the next edge; go to FILL.
  - The policy controller responds one cycle after the pulse, so the nominal stay is 1 cycle. There is no timeout.
- FILL:
  - Each mem_valid_i=1 registers one write to the data array: next cycle cache_we_o=1, cache_addr_o={victim, word_cnt}, cache_data_o=mem_data_i. word_cnt then increments.
  - Words are accepted back-to-back, one per cycle. Gaps are allowed: cache_we_o=0 while mem_valid_i=0.
  - On the valid with word_cnt=BLOCK_WORDS-1: mem_req_o drops on the same edge, word_cnt wraps to 0, go to TAG_WR.
  - mem_valid_i is ignored outside FILL.
- TAG_WR: one cycle. tag_we_o=1, tag_addr_o=victim, tag_data_o={1'b1, tag}. The last data write (cache_we_o) occurs in this same cycle; the two arrays are separate, so there is no conflict.
- DONE: fill_done_o=1 for one cycle; busy_o=0 on the following edge. A miss_i in the DONE cycle is ignored. A miss_i in the first IDLE cycle is accepted.
- Latency: miss_i to first mem_req_o is 3 cycles. fill_done_o is asserted 2 cycles after the last mem_valid_i.
- Width rules: the word counter is BW_OFFSET bits and wraps naturally. Address concatenations are exact widths, with no truncation.

Decomposition:
- Shared package/header: state encodings (IDLE..DONE as localparams), the CLOG2 macro (existing shared header), and the derived widths BW_CACHE_CAPACITY and BW_OFFSET.
- Single module; no sub-module is warranted. Top-level integration instantiates the existing FIFO policy controller alongside this block. The test bench instantiates both.

Test Plan:
- Reset, then a miss with tag 0x00ABCD paired with the FIFO policy controller: policy_req_o pulses 1 cycle; mem_addr_o=0x2AF34; memory returns words 0x11,0x22,0x33,0x44 back-to-back. Required: cache writes to addresses 0,1,2,3 with those data; tag_we_o at tag_addr_o=0 with data 0x100ABCD; fill_done_o pulses once.
- Second miss: victim=1; cache_addr_o=4..7; tag_addr_o=1. After 16 misses the victim wraps to 0 with no gap.
- Memory valids with 2-cycle gaps between words: cache_we_o only in the cycles after each valid; word_cnt does not advance during gaps; the tag write follows the 4th word only.
- policy_done_i held high before the miss (sticky): the victim is taken from the cycle after policy_req_o, not from the POLICY_REQ cycle; the address matches the new counter value.
- miss_i pulsed during FILL and during DONE: both ignored; no second policy_req_o; a miss pulsed in the first IDLE cycle is accepted.
- resetn_i low after 2 of 4 words: all outputs 0 asynchronously; no tag_we_o or fill_done_o. A subsequent miss performs a clean 4-word fill starting at word offset 0.
